// File: rtl/barcode_rx_if.sv
// Barcode receiver interface: serial line and clear strobe in, station ID and status out.
// The receiver uses the slave modport; the driving/consuming side uses master.
interface barcode_rx_if;
  logic       BC;
  logic       clr_ID_vld;
  logic [7:0] ID;
  logic       ID_vld;
  logic       busy;
  logic       frm_err;

  modport slave (
    input  BC,
    input  clr_ID_vld,
    output ID,
    output ID_vld,
    output busy,
    output frm_err
  );

  modport master (
    output BC,
    output clr_ID_vld,
    input  ID,
    input  ID_vld,
    input  busy,
    input  frm_err
  );
endinterface

// File: rtl/barcode_rx.sv
// Self-calibrating barcode station-ID receiver: measures bit time from the start bit, then
// samples 8 MSB-first data bits. Optional WAIT_FALL timeout enabled by macro BC_TIMEOUT_EN.
module barcode_rx #(
  parameter int CNT_W = 22,
  parameter int TO_W  = 24
) (
  input  logic        clk,
  input  logic        rst,
  barcode_rx_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MEAS      = 2'd1,
    ST_WAIT_FALL = 2'd2,
    ST_SAMPLE    = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [2:0]       r_bc_sync;
  logic [CNT_W-1:0] r_per_cnt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_smp_cnt;
  logic [3:0]       r_bit_cnt;
  logic [7:0]       r_shft;
  logic [7:0]       r_id;
  logic             r_id_vld;
  logic             r_busy;
  logic             r_frm_err;

  logic             w_line;
  logic             w_fall;
  logic             w_rise;
  logic             w_per_sat;
  logic             w_per_zero;
  logic             w_smp_hit;
  logic             w_last_bit;
  logic [7:0]       w_shft_nxt;
  logic             w_frame_ok;
  logic             w_to_hit;

  logic             w_per_clr;
  logic             w_per_inc;
  logic             w_period_ld;
  logic             w_bit_clr;
  logic             w_smp_clr;
  logic             w_smp_inc;
  logic             w_shift;
  logic             w_id_ld;
  logic             w_err;

  // Bit 1 is the synchronized level; bit 2 is its one-clk-delayed copy for edge detect.
  assign w_line     = r_bc_sync[1];
  assign w_fall     = r_bc_sync[2] & ~r_bc_sync[1];
  assign w_rise     = ~r_bc_sync[2] & r_bc_sync[1];
  assign w_per_sat  = &r_per_cnt;
  assign w_per_zero = (r_per_cnt == {CNT_W{1'b0}});
  assign w_smp_hit  = (r_smp_cnt == r_period);
  assign w_last_bit = (r_bit_cnt == 4'd7);
  assign w_shft_nxt = {r_shft[6:0], w_line};
  assign w_frame_ok = (w_shft_nxt[7:6] == 2'b00);

`ifdef BC_TIMEOUT_EN
  logic [TO_W-1:0] r_to_cnt;

  // Inter-edge watchdog: only runs while waiting for a data bit's falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= {TO_W{1'b0}};
    end else if ((r_state != ST_WAIT_FALL) || w_fall) begin
      r_to_cnt <= {TO_W{1'b0}};
    end else begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  assign w_to_hit = (r_state == ST_WAIT_FALL) && (&r_to_cnt);
`else
  assign w_to_hit = 1'b0;
`endif

  // Line synchronizer; idles high so reset must not fake a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bc_sync <= 3'b111;
    end else begin
      r_bc_sync <= {r_bc_sync[1:0], bus.BC};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) w_state_nxt = ST_MEAS;
        else        w_state_nxt = ST_IDLE;
      end
      ST_MEAS: begin
        if (w_rise)         w_state_nxt = w_per_zero ? ST_IDLE : ST_WAIT_FALL;
        else if (w_per_sat) w_state_nxt = ST_IDLE;
        else                w_state_nxt = ST_MEAS;
      end
      ST_WAIT_FALL: begin
        if (w_fall)        w_state_nxt = ST_SAMPLE;
        else if (w_to_hit) w_state_nxt = ST_IDLE;
        else               w_state_nxt = ST_WAIT_FALL;
      end
      ST_SAMPLE: begin
        if (w_smp_hit) w_state_nxt = w_last_bit ? ST_IDLE : ST_WAIT_FALL;
        else           w_state_nxt = ST_SAMPLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM output decode: datapath strobes for counters, shifter and result registers.
  always_comb begin
    w_per_clr   = 1'b0;
    w_per_inc   = 1'b0;
    w_period_ld = 1'b0;
    w_bit_clr   = 1'b0;
    w_smp_clr   = 1'b0;
    w_smp_inc   = 1'b0;
    w_shift     = 1'b0;
    w_id_ld     = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_per_clr = w_fall;
        w_bit_clr = w_fall;
      end
      ST_MEAS: begin
        if (w_rise) begin
          if (w_per_zero) w_err       = 1'b1;
          else            w_period_ld = 1'b1;
        end else if (w_per_sat) begin
          w_err = 1'b1;
        end else begin
          w_per_inc = ~w_line;
        end
      end
      ST_WAIT_FALL: begin
        if (w_fall)        w_smp_clr = 1'b1;
        else if (w_to_hit) w_err     = 1'b1;
        else               w_smp_clr = 1'b0;
      end
      ST_SAMPLE: begin
        // Edges before the sample point are deliberately ignored here.
        if (w_smp_hit) begin
          w_shift = 1'b1;
          if (w_last_bit) begin
            if (w_frame_ok) w_id_ld = 1'b1;
            else            w_err   = 1'b1;
          end else begin
            w_id_ld = 1'b0;
          end
        end else begin
          w_smp_inc = 1'b1;
        end
      end
      default: begin
        w_err = 1'b0;
      end
    endcase
  end

  // Period measurement, sample timing, bit counting and deserialization.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_per_cnt <= {CNT_W{1'b0}};
      r_period  <= {CNT_W{1'b0}};
      r_smp_cnt <= {CNT_W{1'b0}};
      r_bit_cnt <= 4'd0;
      r_shft    <= 8'h00;
    end else begin
      if (w_per_clr)      r_per_cnt <= {CNT_W{1'b0}};
      else if (w_per_inc) r_per_cnt <= r_per_cnt + CNT_W'(1);
      else                r_per_cnt <= r_per_cnt;

      if (w_period_ld) r_period <= r_per_cnt;
      else             r_period <= r_period;

      if (w_smp_clr)      r_smp_cnt <= {CNT_W{1'b0}};
      else if (w_smp_inc) r_smp_cnt <= r_smp_cnt + CNT_W'(1);
      else                r_smp_cnt <= r_smp_cnt;

      if (w_bit_clr)    r_bit_cnt <= 4'd0;
      else if (w_shift) r_bit_cnt <= r_bit_cnt + 4'd1;
      else              r_bit_cnt <= r_bit_cnt;

      if (w_shift) r_shft <= w_shft_nxt;
      else         r_shft <= r_shft;
    end
  end

  // Registered outputs; a frame completion setting ID_vld outranks a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id      <= 8'h00;
      r_id_vld  <= 1'b0;
      r_busy    <= 1'b0;
      r_frm_err <= 1'b0;
    end else begin
      r_frm_err <= w_err;
      r_busy    <= (w_state_nxt != ST_IDLE);
      if (w_id_ld) r_id <= w_shft_nxt;
      else         r_id <= r_id;
      if (w_id_ld)             r_id_vld <= 1'b1;
      else if (bus.clr_ID_vld) r_id_vld <= 1'b0;
      else                     r_id_vld <= r_id_vld;
    end
  end

  assign bus.ID      = r_id;
  assign bus.ID_vld  = r_id_vld;
  assign bus.busy    = r_busy;
  assign bus.frm_err = r_frm_err;

endmodule

// File: tb/tb_barcode_rx.sv
// Scoreboard bench for barcode_rx: stimulus pushes expected frame results, a monitor
// pops and compares them on each busy falling edge. Honours BC_TIMEOUT_EN.
module tb_barcode_rx;
  localparam int TB_CNT_W = 22;
`ifdef BC_TIMEOUT_EN
  localparam int TB_TO_W = 8;
`else
  localparam int TB_TO_W = 24;
`endif

  typedef struct packed {
    logic       err;
    logic [7:0] id;
    logic       vld;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic prev_busy = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t exp_q[$];

  barcode_rx_if bus ();

  barcode_rx #(.CNT_W(TB_CNT_W), .TO_W(TB_TO_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #10 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
  endtask

  // Monitor: each busy falling edge (outside reset) is one frame result.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_busy <= 1'b0;
    end else begin
      if (prev_busy && !bus.busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done_qsize", 8'(exp_q.size()), 8'd1);
        end else begin
          e = exp_q.pop_front();
          chk("frm_err", {7'd0, bus.frm_err}, {7'd0, e.err});
          chk("ID", bus.ID, e.id);
          chk("ID_vld", {7'd0, bus.ID_vld}, {7'd0, e.vld});
        end
      end else if (bus.frm_err) begin
        chk("stray_frm_err", {7'd0, bus.frm_err}, 8'd0);
      end
      prev_busy <= bus.busy;
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start bit low t / high t; data '1' low t/2, '0' low 3t/2, each slot 2t long.
  task automatic send_bits(input int t, input logic [7:0] id, input int nbits);
    bus.BC = 1'b0; hold(t);
    bus.BC = 1'b1; hold(t);
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.BC = 1'b0; hold(id[i] ? t / 2 : (3 * t) / 2);
      bus.BC = 1'b1; hold(id[i] ? (3 * t) / 2 : t / 2);
    end
  endtask

  task automatic send_frame(input int t, input logic [7:0] id, input exp_t e);
    exp_q.push_back(e);
    send_bits(t, id, 8);
    hold(2 * t);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    bit ok   = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (bus.busy) seen = 1'b1;
      else if (seen) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_within_bound", {7'd0, ok}, 8'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_ID"}, bus.ID, 8'h00);
    chk({tag, "_ID_vld"}, {7'd0, bus.ID_vld}, 8'd0);
    chk({tag, "_busy"}, {7'd0, bus.busy}, 8'd0);
    chk({tag, "_frm_err"}, {7'd0, bus.frm_err}, 8'd0);
  endtask

  initial begin
    bus.BC = 1'b1;
    bus.clr_ID_vld = 1'b0;
    rst = 1'b1;
    hold(5);
    chk_reset_outputs("reset");
    hold(1);
    rst = 1'b0;
    hold(3);

    send_frame(40, 8'h01, exp_t'{err: 1'b0, id: 8'h01, vld: 1'b1});
    send_frame(48, 8'h02, exp_t'{err: 1'b0, id: 8'h02, vld: 1'b1});

    bus.clr_ID_vld = 1'b1;
    hold(1);
    bus.clr_ID_vld = 1'b0;
    @(negedge clk);
    chk("ID_vld_cleared", {7'd0, bus.ID_vld}, 8'd0);
    hold(1);

    send_frame(32, 8'hC5, exp_t'{err: 1'b1, id: 8'h02, vld: 1'b0});

    // Clear held high across the completion of 0x3F: the set must win.
    bus.clr_ID_vld = 1'b1;
    exp_q.push_back(exp_t'{err: 1'b0, id: 8'h3F, vld: 1'b1});
    fork
      send_bits(40, 8'h3F, 8);
      begin
        wait_done();
        bus.clr_ID_vld = 1'b0;
        @(negedge clk);
        chk("ID_vld_set_beats_clr", {7'd0, bus.ID_vld}, 8'd1);
      end
    join
    hold(80);

    // Reset in the middle of bit 4.
    send_bits(40, 8'h2A, 4);
    bus.BC = 1'b0;
    hold(10);
    rst = 1'b1;
    bus.BC = 1'b1;
    hold(2);
    chk_reset_outputs("midframe_reset");
    hold(1);
    rst = 1'b0;
    hold(3);

    send_frame(36, 8'h15, exp_t'{err: 1'b0, id: 8'h15, vld: 1'b1});

    // Start bit plus three data bits, then the line stays idle high.
`ifdef BC_TIMEOUT_EN
    exp_q.push_back(exp_t'{err: 1'b1, id: 8'h15, vld: 1'b1});
    send_bits(40, 8'hA5, 3);
    hold(600);
    @(negedge clk);
    chk("timeout_busy", {7'd0, bus.busy}, 8'd0);
`else
    send_bits(40, 8'hA5, 3);
    hold(600);
    @(negedge clk);
    chk("stalled_busy", {7'd0, bus.busy}, 8'd1);
    hold(1);
    rst = 1'b1;
    hold(2);
    rst = 1'b0;
    hold(2);
`endif

    hold(10);
    chk("scoreboard_empty", 8'(exp_q.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/barcode_rx.md
Name: barcode_rx

Overview:
- Receives the serial station-ID barcode stream (`BC`) produced by the barcode scanner or `barcode_mimic`.
- Self-calibrates its bit timing from the start bit and deserializes 8 bits, MSB first.
- Presents the station ID to the Follower command/navigation logic with a sticky valid flag.
- Sits directly downstream of `barcode_mimic` and upstream of the Follower state machine.

Parameters:
- CNT_W, 22, width of the period/sample counters; matches the mimic's 22-bit `period`.
- TO_W, 24, width of the inter-edge timeout counter (used only with the optional feature).

Ports:
- clk  input  1  system clock, 50MHz.
- rst  input  1  asynchronous, active-high reset.
- BC  input  1  raw barcode serial line; idles high; asynchronous to `clk`.
- clr_ID_vld  input  1  one-cycle pulse from the consumer that clears `ID_vld`.
- ID  output  8  last accepted station ID.
- ID_vld  output  1  sticky flag: a new valid ID is available.
- busy  output  1  high while a frame is being received.
- frm_err  output  1  one-cycle pulse when a frame is discarded.

Behaviour:
- Reset: `ID`=8'h00, `ID_vld`=0, `busy`=0, `frm_err`=0. Synchronizer flops reset to 1 (idle). FSM goes to IDLE.
- Synchronization:
  - `BC` is double-flopped, then a third flop is used for edge detection.
  - A falling edge is seen 3 clks after the pin falls.
- Frame format:
  - Start bit: a falling edge, then low for duration Ts, then high.
  - 8 data bits: each begins with a falling edge. The bit value is the synchronized line level exactly Ts clks after that edge (high=1, low=0).
  - Bits are shifted in MSB first.
- FSM states: IDLE, MEAS, WAIT_FALL, SAMPLE.
  - IDLE: `busy`=0. On falling edge, clear `per_cnt` and go to MEAS.
  - MEAS: increment `per_cnt` each clk while line is low. On rising edge, latch `per_cnt` into `period` and go to WAIT_FALL.
  - WAIT_FALL: on falling edge, clear `smp_cnt` and go to SAMPLE.
  - SAMPLE: increment `smp_cnt`. When `smp_cnt`==`period`, shift the line level into `shft[0]` and increment `bit_cnt`.
    - If `bit_cnt` reaches 8, go to IDLE and run frame completion.
    - Otherwise go to WAIT_FALL.
- Frame completion:
  - If `shft[7:6`]==2'b00: `ID`<=`shft`, `ID_vld`<=1.
  - Else: `ID` is unchanged and `frm_err` pulses for 1 clk.
- `ID_vld` handling:
  - `ID_vld` stays set until `clr_ID_vld`.
  - If `clr_ID_vld` and a new valid frame completion occur in the same clk, the set wins (`ID_vld`=1).
  - A new valid frame overwrites `ID` even if `ID_vld` is already 1. No backpressure.
- `busy` is high in MEAS, WAIT_FALL and SAMPLE.
- Boundary conditions:
  - If `per_cnt` saturates at all-ones, MEAS aborts: `frm_err` pulses and the FSM returns to IDLE.
  - A measured `period` of 0 (glitch shorter than 1 clk after sync) is treated as a frame error.
  - A rising edge while in WAIT_FALL is ignored.
  - An edge during SAMPLE before the sample point does not restart counting.
- Reset asserted mid-frame: everything returns to reset values immediately (async). The partial frame is lost and no `frm_err` pulse is generated.

Optional Feature:
- Macro: BC_TIMEOUT_EN.
- Defined:
  - A TO_W-bit counter runs in WAIT_FALL and clears on each falling edge.
  - If it reaches all-ones, the frame is aborted: `frm_err` pulses for 1 clk, the FSM returns to IDLE, and `ID`/`ID_vld` are untouched.
- Not defined: the counter is not built, and WAIT_FALL waits indefinitely for the next edge.

Test Plan:
- Reset, then `barcode_mimic` sends `period`=22'h1000, ID 8'h01 -> `ID`=8'h01, `ID_vld` rises once, `busy` falls with it, `frm_err`=0.
- With `ID_vld`=1, send ID 8'h02 without clearing -> `ID`=8'h02, `ID_vld` stays 1. Then pulse `clr_ID_vld` -> `ID_vld`=0 next clk.
- Send ID 8'hC5 (upper bits nonzero) -> `frm_err` pulses once, `ID` keeps its previous value, `ID_vld` unchanged.
- Assert `clr_ID_vld` in the same clk as the completion of ID 8'h3F -> `ID_vld`=1, `ID`=8'h3F.
- Assert `rst` midway through bit 4 of a frame, release, then send ID 8'h15 -> after reset all outputs are 0; after the frame `ID`=8'h15, `ID_vld`=1.
- With BC_TIMEOUT_EN: drive start bit + 3 data bits then hold BC high -> `frm_err` pulses after 2^TO_W-1 clks, `busy`=0, `ID_vld` unchanged. Without the macro: `busy` stays 1.
